div_unit: RTL

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// div_unit: 32-bit iterative restoring divider for DIV / DIVU.
//
// A start pulse in IDLE latches operand magnitudes and sign-correction flags.
// RUN then performs one shift/subtract step per cycle for exactly 32 cycles.
// The sign-corrected results are written to q/r on the edge that enters DONE.
// DONE lasts one cycle (over pulse), after which the block returns to IDLE.
//
// Ports:
//   clk_in     in   1   rising-edge clock
//   reset      in   1   asynchronous active-high reset
//   start      in   1   request; accepted only in IDLE
//   is_signed  in   1   1 = DIV (two's complement), 0 = DIVU
//   dividend   in  32   rs operand
//   divisor    in  32   rt operand
//   q          out 32   quotient (LO); held until the next completion
//   r          out 32   remainder (HI); held until the next completion
//   busy       out  1   high while RUN
//   over       out  1   one-cycle completion pulse (DONE)
//
// state | meaning
// IDLE  | waiting for start; q/r hold the last result
// RUN   | 32 restoring shift/subtract steps, one per cycle
// DONE  | results valid, over pulse for one cycle

module div_unit (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] q,
  output logic [31:0] r,
  output logic        busy,
  output logic        over
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] quo_q, quo_d;   // dividend bits shift out the top, quotient bits in at the bottom
  logic [31:0] den_q, den_d;
  logic [31:0] rem_q, rem_d;
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;
  logic [31:0] q_q, q_d;
  logic [31:0] r_q, r_d;

  logic [31:0] dvd_abs, dvs_abs;
  logic [32:0] shifted;
  logic        fits;
  logic [31:0] rem_step, quo_step;
  logic [31:0] q_res, r_res;

  // Magnitudes; negating 0x80000000 wraps back to 0x80000000, which is the
  // correct unsigned magnitude.
  assign dvd_abs = (is_signed && dividend[31]) ? (~dividend + 32'd1) : dividend;
  assign dvs_abs = (is_signed && divisor[31])  ? (~divisor + 32'd1)  : divisor;

  // Trial subtract needs 33 bits: the shifted partial remainder can exceed
  // 2^32-1 when the divisor is above 2^31. When it fits, the true difference
  // is below the divisor, so the 32-bit wrapped difference is exact.
  assign shifted  = {rem_q, quo_q[31]};
  assign fits     = (shifted >= {1'b0, den_q});
  assign rem_step = fits ? (shifted[31:0] - den_q) : shifted[31:0];
  assign quo_step = {quo_q[30:0], fits};

  // Divide by zero: the raw algorithm leaves |dividend| in the remainder, so
  // the sign-corrected remainder is already the original dividend; only the
  // quotient needs forcing to all ones.
  assign q_res = (den_q == 32'd0) ? 32'hFFFF_FFFF
               : (negq_q ? (~quo_step + 32'd1) : quo_step);
  assign r_res = negr_q ? (~rem_step + 32'd1) : rem_step;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    den_d   = den_q;
    rem_d   = rem_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    q_d     = q_q;
    r_d     = r_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = 5'd0;
          quo_d   = dvd_abs;
          den_d   = dvs_abs;
          rem_d   = 32'd0;
          negq_d  = is_signed & (dividend[31] ^ divisor[31]);
          negr_d  = is_signed & dividend[31];
        end
      end
      RUN: begin
        quo_d = quo_step;
        rem_d = rem_step;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = DONE;
          q_d     = q_res;
          r_d     = r_res;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      quo_q   <= 32'd0;
      den_q   <= 32'd0;
      rem_q   <= 32'd0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      q_q     <= 32'd0;
      r_q     <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      den_q   <= den_d;
      rem_q   <= rem_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      q_q     <= q_d;
      r_q     <= r_d;
    end
  end

  assign q    = q_q;
  assign r    = r_q;
  assign busy = (state_q == RUN);
  assign over = (state_q == DONE);

endmodule
